// File: rtl/vga_timing_core.sv
// vga_timing_core
// VGA raster timing generator: pixel/line counters, sync pulses, active-video
// flag, line/frame start strobes and an optional frame counter. Defaults give
// 640x480@60 from a 25.175 MHz pixel clock.
//
// Build option: define VGA_TIMING_FRAME_CNT_EN to build the frame_no counter.
// Without it the frame_no port is tied to zero and frame_start still pulses.
//
// Every output is a register. The sync and display flags are computed from the
// next counter values, so they always describe the hpos/vpos shown in the same
// cycle. Reset is synchronous and active-low.

module vga_timing_core #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int HSYNC_POL  = 0,
   parameter int VSYNC_POL  = 0,
   parameter int FRAME_BITS = 9
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ce,
   output logic [9:0]            hpos,
   output logic [9:0]            vpos,
   output logic                  hsync,
   output logic                  vsync,
   output logic                  display_on,
   output logic                  line_start,
   output logic                  frame_start,
   output logic [FRAME_BITS-1:0] frame_no
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic       HS_ACT   = 1'(HSYNC_POL);
   localparam logic       VS_ACT   = 1'(VSYNC_POL);

   // The counters are 10 bits wide, so neither raster dimension may exceed 1024.
   generate
      if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_bad_totals
         $error("vga_timing_core: H_TOTAL and V_TOTAL must both be <= 1024");
      end
   endgenerate

   logic [9:0] r_hpos;
   logic [9:0] r_vpos;
   logic       r_hsync;
   logic       r_vsync;
   logic       r_display_on;
   logic       r_line_start;
   logic       r_frame_start;

   logic [9:0] w_hpos_nxt;
   logic [9:0] w_vpos_nxt;
   logic       w_line_wrap;
   logic       w_frame_wrap;
   logic       w_hsync_on;
   logic       w_vsync_on;
   logic       w_display_nxt;

   // Next raster position, plus the line/frame wrap events this advance causes.
   always_comb begin
      w_hpos_nxt   = r_hpos;
      w_vpos_nxt   = r_vpos;
      w_line_wrap  = 1'b0;
      w_frame_wrap = 1'b0;
      if (ce) begin
         if (r_hpos < H_LAST) begin
            w_hpos_nxt = r_hpos + 10'd1;
         end else begin
            w_hpos_nxt  = 10'd0;
            w_line_wrap = 1'b1;
            if (r_vpos < V_LAST) begin
               w_vpos_nxt = r_vpos + 10'd1;
            end else begin
               w_vpos_nxt   = 10'd0;
               w_frame_wrap = 1'b1;
            end
         end
      end else begin
         w_hpos_nxt = r_hpos;
         w_vpos_nxt = r_vpos;
      end
   end

   // Sync and visible-area decode of the next position, so flags stay aligned.
   always_comb begin
      w_hsync_on    = (w_hpos_nxt >= HS_START) && (w_hpos_nxt <= HS_END);
      w_vsync_on    = (w_vpos_nxt >= VS_START) && (w_vpos_nxt <= VS_END);
      w_display_nxt = (w_hpos_nxt < H_VIS) && (w_vpos_nxt < V_VIS);
   end

   // Raster registers; strobes only fire on a real wrap, never on reset or hold.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_hpos        <= 10'd0;
         r_vpos        <= 10'd0;
         r_hsync       <= ~HS_ACT;
         r_vsync       <= ~VS_ACT;
         r_display_on  <= 1'b1;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_hpos        <= w_hpos_nxt;
         r_vpos        <= w_vpos_nxt;
         r_hsync       <= w_hsync_on ? HS_ACT : ~HS_ACT;
         r_vsync       <= w_vsync_on ? VS_ACT : ~VS_ACT;
         r_display_on  <= w_display_nxt;
         r_line_start  <= w_line_wrap;
         r_frame_start <= w_frame_wrap;
      end
   end

`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [FRAME_BITS-1:0] r_frame_no;

   // Frames completed since reset; steps on the same edge that raises frame_start.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_frame_no <= {FRAME_BITS{1'b0}};
      end else if (w_frame_wrap) begin
         r_frame_no <= r_frame_no + FRAME_BITS'(1);
      end else begin
         r_frame_no <= r_frame_no;
      end
   end

   assign frame_no = r_frame_no;
`else
   assign frame_no = {FRAME_BITS{1'b0}};
`endif

   assign hpos        = r_hpos;
   assign vpos        = r_vpos;
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign display_on  = r_display_on;
   assign line_start  = r_line_start;
   assign frame_start = r_frame_start;

endmodule
